// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, command kinds and loader FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Command kinds presented on cmd_kind; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4,
    KIND_J     = 3'd5
  } cmd_kind_e;

  // Loader FSM state encoding, kept as plain constants for older tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCEPT = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/instr_encode.sv
// Combinational field-to-word encoder for the instruction loader.
// Illegal kinds encode to 0x00000000 (NOP) and raise illegal_o; an RTYPE
// whose cmd_imm[10:6] (the shamt position) is nonzero raises shamtNz_o.
// The shamt field of the written RTYPE word is always 00000.
module instr_encode
  import mips_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        shamtNz_o
);

  // Select the instruction format for the kind and pack its fields.
  always_comb begin
    word_o    = 32'h0000_0000;
    illegal_o = 1'b0;
    shamtNz_o = 1'b0;
    case (kind_i)
      KIND_RTYPE: begin
        word_o    = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
        shamtNz_o = |imm_i[10:6];
      end
      KIND_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      KIND_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      KIND_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      KIND_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      KIND_J:    word_o = {OP_J, target_i};
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts encoded-instruction commands after a start
// pulse and writes one 32-bit word per command into instruction memory at
// consecutive word addresses from base_addr.
// Optional feature macro: INSTR_LOADER_CHECK_EN enables the sticky err flag
// for illegal kinds and nonzero RTYPE shamt.
module instr_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_kind,
  input  logic [4:0]                 cmd_rs,
  input  logic [4:0]                 cmd_rt,
  input  logic [4:0]                 cmd_rd,
  input  logic [5:0]                 cmd_funct,
  input  logic [15:0]                cmd_imm,
  input  logic [25:0]                cmd_target,
  input  logic                       cmd_last,
  output logic                       imem_we,
  output logic [AW-1:0]              imem_addr,
  output logic [31:0]                imem_wd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic [AW-1:0]   nextAddr_q, nextAddr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;

  logic [31:0]     encWord;
  logic            illegalKind;
  logic            shamtNz;
  logic            handshake;
  logic            checkFail;

  instr_encode uEncode (
    .kind_i   (cmd_kind),
    .rs_i     (cmd_rs),
    .rt_i     (cmd_rt),
    .rd_i     (cmd_rd),
    .funct_i  (cmd_funct),
    .imm_i    (cmd_imm),
    .target_i (cmd_target),
    .word_o   (encWord),
    .illegal_o(illegalKind),
    .shamtNz_o(shamtNz)
  );

`ifdef INSTR_LOADER_CHECK_EN
  assign checkFail = illegalKind | shamtNz;
`else
  logic unusedCheckFlags;
  assign unusedCheckFlags = illegalKind | shamtNz;
  assign checkFail        = 1'b0;
`endif

  assign handshake = cmd_valid && (state_q == ST_ACCEPT);

  // Next-state logic: session control, word counting and the write register.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    nextAddr_d = nextAddr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ACCEPT;
          count_d    = '0;
          err_d      = 1'b0;
          nextAddr_d = base_addr;
        end
      end
      ST_ACCEPT: begin
        if (handshake) begin
          we_d       = 1'b1;
          addr_d     = nextAddr_q;
          wd_d       = encWord;
          nextAddr_d = nextAddr_q + AW'(4);
          count_d    = count_q + CW'(1);
          err_d      = err_q | checkFail;
          if (cmd_last || (count_q == CW'(DEPTH - 1))) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any write captured in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      err_q      <= 1'b0;
      nextAddr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      nextAddr_q <= nextAddr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
    end
  end

  assign cmd_ready = (state_q == ST_ACCEPT);
  assign done      = (state_q == ST_FINISH);
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (DEPTH=4) with a write scoreboard.
module tb_instr_loader;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_kind;
  logic [4:0]    cmd_rs, cmd_rt, cmd_rd;
  logic [5:0]    cmd_funct;
  logic [15:0]   cmd_imm;
  logic [25:0]   cmd_target;
  logic          cmd_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [CW-1:0] count;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        done;
  } exp_t;

  exp_t        sbQ[$];
  int          numChecks = 0;
  int          numFails  = 0;
  logic [31:0] expBase   = 32'h0;
  int          sessIdx   = 0;
  logic        expErrIllegal;

  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_rd    (cmd_rd),
    .cmd_funct (cmd_funct),
    .cmd_imm   (cmd_imm),
    .cmd_target(cmd_target),
    .cmd_last  (cmd_last),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Opens a session at the given base address with a one-cycle start pulse.
  task automatic startSession(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    expBase   = base;
    sessIdx   = 0;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Presents one command and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                               input logic [25:0] target, input logic last, input logic [31:0] expWord,
                               input logic mustAccept);
    int   waitCycles;
    logic accepted;
    exp_t e;
    waitCycles = 0;
    accepted   = 1'b0;
    cmd_kind   = kind;
    cmd_rs     = rs;
    cmd_rt     = rt;
    cmd_rd     = rd;
    cmd_funct  = funct;
    cmd_imm    = imm;
    cmd_target = target;
    cmd_last   = last;
    cmd_valid  = 1'b1;
    while (!accepted && waitCycles < 8) begin
      if (cmd_ready) begin
        e.addr = expBase + 32'(4 * sessIdx);
        e.wd   = expWord;
        e.done = last || (sessIdx + 1 == DEPTH);
        sbQ.push_back(e);
        sessIdx++;
        accepted = 1'b1;
      end else begin
        waitCycles++;
      end
      @(negedge clk);
    end
    if (!accepted && mustAccept) checkOutput("accept_timeout", 64'(accepted), 64'd1);
  endtask

  // Drops cmd_valid and idles for a few cycles so pending writes drain.
  task automatic idleCycles(input int n);
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (imem_we) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_write", 64'(imem_addr), 64'hFFFF_FFFF);
        end else begin
          e = sbQ.pop_front();
          checkOutput("wr_addr", 64'(imem_addr), 64'(e.addr));
          checkOutput("wr_data", 64'(imem_wd), 64'(e.wd));
          checkOutput("wr_done", 64'(done), 64'(e.done));
        end
      end else if (done) begin
        checkOutput("done_without_write", 64'(imem_we), 64'd1);
      end
    end
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
`ifdef INSTR_LOADER_CHECK_EN
    expErrIllegal = 1'b1;
`else
    expErrIllegal = 1'b0;
`endif
    reset = 1'b1; start = 1'b0; base_addr = '0; cmd_valid = 1'b0;
    cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_funct = '0;
    cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;
    #12;
    checkOutput("rst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_we",    64'(imem_we),   64'd0);
    checkOutput("rst_addr",  64'(imem_addr), 64'd0);
    checkOutput("rst_wd",    64'(imem_wd),   64'd0);
    checkOutput("rst_count", 64'(count),     64'd0);
    checkOutput("rst_done",  64'(done),      64'd0);
    checkOutput("rst_err",   64'(err),       64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single ADDI session at 0x40.
    startSession(32'h40);
    checkOutput("ready_in_accept", 64'(cmd_ready), 64'd1);
    applyStimulus(KIND_ADDI, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005, 1'b1);
    idleCycles(3);
    checkOutput("addi_count", 64'(count), 64'd1);
    checkOutput("addi_err",   64'(err),   64'd0);

    // Back-to-back LW, SW, BEQ from address 0.
    startSession(32'h0);
    applyStimulus(KIND_LW,  5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 32'h8D09_0004, 1'b1);
    applyStimulus(KIND_SW,  5'd0, 5'd9, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, 32'hAC09_0008, 1'b1);
    applyStimulus(KIND_BEQ, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 32'h1109_FFFF, 1'b1);
    idleCycles(3);
    checkOutput("mem_count", 64'(count), 64'd3);

    // RTYPE followed by J.
    startSession(32'h200);
    applyStimulus(KIND_RTYPE, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0, 32'h0109_5020, 1'b1);
    applyStimulus(KIND_J,     5'd0, 5'd0, 5'd0,  6'd0,  16'd0, 26'h10, 1'b1, 32'h0800_0010, 1'b1);
    idleCycles(3);
    checkOutput("rj_count", 64'(count), 64'd2);

    // Illegal kind writes a NOP at a wrapping address.
    startSession(32'hFFFF_FFFC);
    applyStimulus(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 32'h8C21_0001, 1'b1);
    applyStimulus(3'd7, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hABCD, 26'h3FF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    idleCycles(3);
    checkOutput("illegal_err", 64'(err), 64'(expErrIllegal));

    // Six commands without cmd_last stop at DEPTH writes.
    startSession(32'h1000);
    checkOutput("start_clears_err", 64'(err), 64'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(KIND_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'(i + 1), 26'd0, 1'b0,
                    {6'b001000, 5'd1, 5'd2, 16'(i + 1)}, (i < DEPTH) ? 1'b1 : 1'b0);
    end
    checkOutput("depth_ready", 64'(cmd_ready), 64'd0);
    idleCycles(2);
    checkOutput("depth_count", 64'(count), 64'd4);

    // Reset in the middle of a session, with a handshake pending.
    startSession(32'h300);
    applyStimulus(KIND_ADDI, 5'd0, 5'd1, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0, 32'h2001_0007, 1'b1);
    applyStimulus(KIND_ADDI, 5'd0, 5'd2, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0, 32'h2002_0008, 1'b1);
    cmd_kind = KIND_ADDI; cmd_rt = 5'd3; cmd_imm = 16'd9; cmd_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("mid_rst_we",    64'(imem_we),   64'd0);
    checkOutput("mid_rst_addr",  64'(imem_addr), 64'd0);
    checkOutput("mid_rst_wd",    64'(imem_wd),   64'd0);
    checkOutput("mid_rst_count", 64'(count),     64'd0);
    checkOutput("mid_rst_done",  64'(done),      64'd0);
    checkOutput("mid_rst_err",   64'(err),       64'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_drops_write", 64'(imem_we), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    startSession(32'h300);
    checkOutput("restart_count", 64'(count), 64'd0);
    applyStimulus(KIND_ADDI, 5'd0, 5'd4, 5'd0, 6'd0, 16'd1, 26'd0, 1'b1, 32'h2004_0001, 1'b1);
    idleCycles(3);
    checkOutput("restart_final_count", 64'(count), 64'd1);
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
